alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle ALU for the Cortex-M0 execute stage. It takes one operation per valid/ready handshake and computes all four NZCV flags, including V. Results and flags are held in an output register until the downstream stage accepts them. Single-cycle ops complete in one cycle; MUL(S) runs on an iterative shift-add unit whose speed is set by a parameter.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must be ≥ 8 and a power of 2
- MUL_BPC, 1, multiplier bits retired per cycle; must be 1, 2 or 4 and divide DATA_W

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted when in_valid & in_ready
- op  in  4  opcode, from Defines.v
- a  in  DATA_W  first operand (Rn)
- b  in  DATA_W  second operand (Rm/immediate); value to shift for shift ops
- shamt  in  8  shift amount (Rs[7:0] or imm_shift)
- set_flags  in  1  S bit
- flags_in  in  4  current {N,Z,C,V}
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream accepts the result
- result  out  DATA_W  registered result
- flags_out  out  4  registered {N,Z,C,V}

## Operation
Opcodes:
- ADD, ADC, SUB, SBC, AND, ORR, EOR, BIC, MVN, MOV, LSL, LSR, ASR, ROR, MUL

Arithmetic:
- SUB = a + ~b + 1; SBC = a + ~b + C_in; C = carry out of bit DATA_W-1 (ARM no-borrow convention)
- V = (a[msb] == b'[msb]) & (res[msb] != a[msb]), where b' is the effective addend after inversion

Shifts (operand b, amount s = shamt):
- s = 0: result = b, C unchanged
- LSL, 0 < s < DATA_W: C = b[DATA_W-s]; s = DATA_W: result 0, C = b[0]; s > DATA_W: result 0, C = 0
- LSR: mirror of LSL; s = DATA_W gives C = b[msb]
- ASR, s ≥ DATA_W: result all sign bits, C = b[msb]
- ROR: rotate by s mod DATA_W; C = result[msb]; s a nonzero multiple of DATA_W gives result = b

Flags:
- Logic ops and MOV/MVN: C and V unchanged
- Shifts: V unchanged
- MUL: result = low DATA_W bits of a*b; N and Z updated, C and V unchanged
- set_flags = 0: flags_out = flags_in sampled at accept time
- Z = (result == 0); N = result[msb]

Unknown op:
- result 0, flags_out = flags_in, normal 1-cycle completion

FSM states:
- IDLE: in_ready = 1. On accept, a non-MUL op loads the output register and goes to DONE; MUL loads the multiplier and goes to MUL.
- MUL: iteration counter counts DATA_W/MUL_BPC cycles, then loads the output register and goes to DONE. in_ready = 0.
- DONE: out_valid = 1; result and flags stay stable until out_valid & out_ready. in_ready = out_ready, so back-to-back acceptance is allowed. Accepting a new op in the same cycle re-enters DONE or MUL; otherwise the FSM goes to IDLE.

## Timing
Reset (rst = 0 at an edge):
- state = IDLE; out_valid 0; result 0; flags_out 0000; counter 0
- in_ready is 0 during reset and 1 after it
- Reset mid-MUL or in DONE discards the operation

Latency:
- non-MUL: out_valid the cycle after accept
- MUL: out_valid DATA_W/MUL_BPC + 1 cycles after accept (33 at defaults)

Throughput:
- 1 op/cycle for non-MUL with out_ready held high
- Operands and flags_in are captured at accept; later input changes are ignored
- out_valid stays high under backpressure; result must not change until the handshake

## Structure
- Opcode and flag-index constants (`ALU_ADD…`, `F_N/F_Z/F_C/F_V`) are added to Defines.v.
- Sub-module mul_iter(DATA_W, MUL_BPC): start/busy/done, shift-add, low-half product.
- The shifter and adder stay inline in alu_mc.

## Test plan
- Reset: hold rst = 0 for 2 cycles mid-MUL → out_valid 0, flags_out 0000, in_ready 1 on the first cycle after release.
- ADD, set_flags = 1: a = 0x7FFFFFFF, b = 1 → result 0x80000000, NZCV = 1001. SUB: a = 5, b = 5 → 0, NZCV = 0110.
- Shifts with flags_in C = 1:
  - LSL b = 0x80000001, s = 1 → 0x00000002, C = 1
  - LSR s = 32 → 0, C = 1
  - ASR b = 0x80000000, s = 40 → 0xFFFFFFFF, C = 1
  - s = 0 → b, C = 1
- MUL a = 0xFFFFFFFF, b = 3, MUL_BPC = 1 → out_valid exactly 33 cycles after accept, result 0xFFFFFFFD, N = 1, C/V = flags_in. Repeat with MUL_BPC = 4 → 9 cycles.
- Backpressure: out_ready = 0 for 5 cycles after an ADD → result stable, in_ready 0; on release, a new op accepted the same cycle.
- Streaming: 8 back-to-back ANDs with in_valid = out_ready = 1 → 8 results on 8 consecutive cycles in order; with set_flags = 0, flags_out = flags_in.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the multi-cycle ALU.
// Flags are packed as {N,Z,C,V}.
package alu_mc_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SBC = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_ORR = 4'd5;
  localparam logic [3:0] ALU_EOR = 4'd6;
  localparam logic [3:0] ALU_BIC = 4'd7;
  localparam logic [3:0] ALU_MVN = 4'd8;
  localparam logic [3:0] ALU_MOV = 4'd9;
  localparam logic [3:0] ALU_LSL = 4'd10;
  localparam logic [3:0] ALU_LSR = 4'd11;
  localparam logic [3:0] ALU_ASR = 4'd12;
  localparam logic [3:0] ALU_ROR = 4'd13;
  localparam logic [3:0] ALU_MUL = 4'd14;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [3:0] opc);
    return opc == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier returning the low DATA_W bits of a*b.
// Retires MUL_BPC multiplier bits per cycle; done pulses one cycle after the last step.
module mul_iter
  import alu_mc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int ITERS = DATA_W / MUL_BPC;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [CNT_W-1:0]  cnt_p1;
  logic              busy_p1;
  logic              done_p1;
  logic [DATA_W-1:0] acc_p1;
  logic [DATA_W-1:0] mcand_p1;
  logic [DATA_W-1:0] mplier_p1;
  logic [DATA_W-1:0] partial;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (mplier_p1[j]) partial = partial + (mcand_p1 << j);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_p1  <= '0;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= 1'b0;
      if (start) begin
        cnt_p1  <= CNT_W'(ITERS);
        busy_p1 <= 1'b1;
      end else if (busy_p1) begin
        cnt_p1 <= cnt_p1 - CNT_W'(1);
        if (cnt_p1 == CNT_W'(1)) begin
          busy_p1 <= 1'b0;
          done_p1 <= 1'b1;
        end
      end
    end
  end

  // ---- iteration datapath: accumulate partial product, shift operands ----
  always_ff @(posedge clk) begin
    if (start) begin
      acc_p1    <= '0;
      mcand_p1  <= a;
      mplier_p1 <= b;
    end else if (busy_p1) begin
      acc_p1    <= acc_p1 + partial;
      mcand_p1  <= mcand_p1 << MUL_BPC;
      mplier_p1 <= mplier_p1 >> MUL_BPC;
    end
  end

  assign busy    = busy_p1;
  assign done    = done_p1;
  assign product = acc_p1;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle Cortex-M0 execute ALU: single-cycle add/logic/shift ops plus an
// iterative MUL, with a held result/flag register and valid/ready on both sides.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        shamt,
  input  logic              set_flags,
  input  logic [3:0]        flags_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags_out
);

  localparam int MSB = DATA_W - 1;
  localparam int SW  = $clog2(DATA_W);

  state_t state_p1, state_nx;

  logic              accept;
  logic              load_alu;
  logic              load_mul;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;

  logic [DATA_W-1:0] res_p1;
  logic [3:0]        flags_p1;
  logic              mul_sf_p1;
  logic [3:0]        mul_fin_p1;

  logic [DATA_W-1:0]        b_eff;
  logic                     cin;
  logic [DATA_W:0]          sum;
  logic                     add_v;
  logic [DATA_W:0]          lsl_t;
  logic [DATA_W:0]          lsr_t;
  logic signed [DATA_W:0]   asr_t;
  logic [DATA_W-1:0]        ror_res;
  logic                     sh_zero;
  logic [DATA_W-1:0]        alu_res;
  logic [3:0]               alu_flags;
  logic                     c_new;
  logic                     v_new;
  logic                     nz_upd;
  logic [3:0]               mul_flags;

  // ---- adder: SUB/SBC invert b, carry-in per opcode (ARM no-borrow carry) ----
  always_comb begin
    b_eff = ((op == ALU_SUB) || (op == ALU_SBC)) ? ~b : b;
    case (op)
      ALU_ADC, ALU_SBC: cin = flags_in[F_C];
      ALU_SUB:          cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
    add_v = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
  end

  // Shifts use one extra guard bit so the last bit shifted out lands at a
  // fixed position, which covers s == DATA_W and s > DATA_W without special cases.
  always_comb begin
    sh_zero = (shamt == 8'd0);
    lsl_t   = {1'b0, b} << shamt;
    lsr_t   = {b, 1'b0} >> shamt;
    asr_t   = $signed({b, 1'b0}) >>> shamt;
    ror_res = DATA_W'({b, b} >> shamt[SW-1:0]);
  end

  always_comb begin
    alu_res = '0;
    c_new   = flags_in[F_C];
    v_new   = flags_in[F_V];
    nz_upd  = 1'b1;
    case (op)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
        alu_res = sum[DATA_W-1:0];
        c_new   = sum[DATA_W];
        v_new   = add_v;
      end
      ALU_AND: alu_res = a & b;
      ALU_ORR: alu_res = a | b;
      ALU_EOR: alu_res = a ^ b;
      ALU_BIC: alu_res = a & ~b;
      ALU_MVN: alu_res = ~b;
      ALU_MOV: alu_res = b;
      ALU_LSL: begin
        alu_res = lsl_t[DATA_W-1:0];
        if (!sh_zero) c_new = lsl_t[DATA_W];
      end
      ALU_LSR: begin
        alu_res = lsr_t[DATA_W:1];
        if (!sh_zero) c_new = lsr_t[0];
      end
      ALU_ASR: begin
        alu_res = asr_t[DATA_W:1];
        if (!sh_zero) c_new = asr_t[0];
      end
      ALU_ROR: begin
        alu_res = ror_res;
        if (!sh_zero) c_new = ror_res[MSB];
      end
      default: nz_upd = 1'b0;
    endcase
    if (set_flags && nz_upd)
      alu_flags = {alu_res[MSB], (alu_res == '0), c_new, v_new};
    else
      alu_flags = flags_in;
  end

  assign mul_flags = mul_sf_p1 ? {mul_prod[MSB], (mul_prod == '0), mul_fin_p1[F_C], mul_fin_p1[F_V]}
                               : mul_fin_p1;

  mul_iter #(
    .DATA_W  (DATA_W),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (!rst) state_p1 <= ST_IDLE;
    else      state_p1 <= state_nx;
  end

  always_comb begin
    state_nx = state_p1;
    case (state_p1)
      ST_IDLE: if (accept) state_nx = is_mul(op) ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done && !mul_busy) state_nx = ST_DONE;
      ST_DONE: begin
        if (accept)         state_nx = is_mul(op) ? ST_MUL : ST_DONE;
        else if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_p1)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
    if (!rst) in_ready = 1'b0;
  end

  assign accept    = in_valid && in_ready;
  assign load_alu  = accept && !is_mul(op);
  assign mul_start = accept && is_mul(op);
  assign load_mul  = (state_p1 == ST_MUL) && mul_done && !mul_busy;

  // ---- output register: held until the downstream handshake ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_p1   <= '0;
      flags_p1 <= 4'b0000;
    end else if (load_alu) begin
      res_p1   <= alu_res;
      flags_p1 <= alu_flags;
    end else if (load_mul) begin
      res_p1   <= mul_prod;
      flags_p1 <= mul_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (mul_start) begin
      mul_sf_p1  <= set_flags;
      mul_fin_p1 <= flags_in;
    end
  end

  assign result    = res_p1;
  assign flags_out = flags_p1;

endmodule
